// File: rtl/parity_frame_checker.sv
// Frame parity checker: folds per-beat XNOR results over FRAME_LEN data beats plus one check beat.
// Latency: out_valid/counters update one cycle after the check beat is accepted.
// Backpressure: in_ready drops while a result waits; the result is held until out_ready.
module parity_frame_checker #(
  parameter int FRAME_LEN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       soft_clr,
  input  logic       in_valid,
  input  logic       in_xnor,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_ok,
  output logic [7:0] frame_count,
  output logic [7:0] err_count,
  output logic       busy
);

  localparam int CNT_W = (FRAME_LEN < 1) ? 1 : $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(FRAME_LEN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic             acc, acc_nx;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nx;
  logic             frame_ok_nx;
  logic [7:0]       frame_count_nx, err_count_nx;

  logic accept;
  logic par;
  logic acc_par;

  // Handshake outputs come from registered state only, never from in_valid/out_ready.
  assign in_ready  = (state != REPORT);
  assign out_valid = (state == REPORT);
  assign busy      = (state != IDLE);

  assign accept  = in_valid && in_ready;
  assign par     = ~in_xnor;
  assign acc_par = acc ^ par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= 1'b0;
      beat_cnt    <= '0;
      frame_ok    <= 1'b0;
      frame_count <= 8'd0;
      err_count   <= 8'd0;
    end else begin
      state       <= state_nx;
      acc         <= acc_nx;
      beat_cnt    <= beat_cnt_nx;
      frame_ok    <= frame_ok_nx;
      frame_count <= frame_count_nx;
      err_count   <= err_count_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    acc_nx         = acc;
    beat_cnt_nx    = beat_cnt;
    frame_ok_nx    = frame_ok;
    frame_count_nx = frame_count;
    err_count_nx   = err_count;

    if (soft_clr) begin
      // Clear wins over everything, including a beat offered this cycle.
      state_nx       = IDLE;
      acc_nx         = 1'b0;
      beat_cnt_nx    = '0;
      frame_ok_nx    = 1'b0;
      frame_count_nx = 8'd0;
      err_count_nx   = 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            acc_nx      = par;
            beat_cnt_nx = CNT_W'(1);
            state_nx    = ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            if (beat_cnt < LAST_DATA) begin
              acc_nx      = acc_par;
              beat_cnt_nx = beat_cnt + CNT_W'(1);
            end else begin
              // Check beat: odd total parity means the frame failed.
              frame_ok_nx    = ~acc_par;
              frame_count_nx = frame_count + 8'd1;
              if (acc_par && (err_count != 8'hFF)) begin
                err_count_nx = err_count + 8'd1;
              end
              state_nx = REPORT;
            end
          end
        end
        REPORT: begin
          if (out_ready) begin
            state_nx = IDLE;
          end
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Randomized and directed bench for parity_frame_checker against a frame-level queue model.
module tb_parity_frame_checker;

  localparam int FRAME_LEN = 4;

  logic       clk;
  logic       rst_n;
  logic       soft_clr;
  logic       in_valid;
  logic       in_xnor;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic       frame_ok;
  logic [7:0] frame_count;
  logic [7:0] err_count;
  logic       busy;

  int tests;
  int fails;

  // Reference model: beats of the open frame, pending-result flag, counters.
  bit q[$];
  bit m_report;
  bit m_ok;
  int m_fc;
  int m_ec;

  parity_frame_checker #(.FRAME_LEN(FRAME_LEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .soft_clr   (soft_clr),
    .in_valid   (in_valid),
    .in_xnor    (in_xnor),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_ok   (frame_ok),
    .frame_count(frame_count),
    .err_count  (err_count),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    q.delete();
    m_report = 1'b0;
    m_ok     = 1'b0;
    m_fc     = 0;
    m_ec     = 0;
  endtask

  // One clock: drive after the falling edge, update the model at the rising edge, settle #1.
  task automatic step(input bit iv, input bit ix, input bit ordy, input bit sclr);
    int odd_nibbles;
    @(negedge clk);
    in_valid  = iv;
    in_xnor   = ix;
    out_ready = ordy;
    soft_clr  = sclr;
    @(posedge clk);
    if (sclr) begin
      model_clear();
    end else if (m_report) begin
      if (ordy) m_report = 1'b0;
    end else if (iv) begin
      q.push_back(ix);
      if (q.size() == FRAME_LEN + 1) begin
        odd_nibbles = 0;
        foreach (q[i]) if (q[i] == 1'b0) odd_nibbles++;
        m_ok = (odd_nibbles % 2 == 0);
        m_fc = (m_fc + 1) % 256;
        if (!m_ok && m_ec < 255) m_ec++;
        q.delete();
        m_report = 1'b1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in_xnor   = 1'b0;
    out_ready = 1'b0;
    soft_clr  = 1'b0;
    rst_n     = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if (frame_ok !== 1'b0) begin fails++; $display("FAIL reset_frame_ok got %b want 0", frame_ok); end
    tests++; if (frame_count !== 8'd0) begin fails++; $display("FAIL reset_frame_count got %0d want 0", frame_count); end
    tests++; if (err_count !== 8'd0) begin fails++; $display("FAIL reset_err_count got %0d want 0", err_count); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_basic_frame();
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_out_valid got %b want 1", out_valid); end
    tests++; if (frame_ok !== 1'b1) begin fails++; $display("FAIL basic_frame_ok got %b want 1", frame_ok); end
    tests++; if (frame_count !== 8'd1) begin fails++; $display("FAIL basic_frame_count got %0d want 1", frame_count); end
    tests++; if (err_count !== 8'd0) begin fails++; $display("FAIL basic_err_count got %0d want 0", err_count); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL basic_in_ready_low got %b want 0", in_ready); end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL basic_in_ready_back got %b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_out_valid_drop got %b want 0", out_valid); end
  endtask

  task automatic test_patterns();
    bit pat_a[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    bit pat_b[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    foreach (pat_a[i]) step(1'b1, pat_a[i], 1'b1, 1'b0);
    tests++; if (frame_ok !== 1'b0) begin fails++; $display("FAIL pat_a_frame_ok got %b want 0", frame_ok); end
    tests++; if (err_count !== 8'd1) begin fails++; $display("FAIL pat_a_err_count got %0d want 1", err_count); end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    foreach (pat_b[i]) step(1'b1, pat_b[i], 1'b1, 1'b0);
    tests++; if (frame_ok !== 1'b1) begin fails++; $display("FAIL pat_b_frame_ok got %b want 1", frame_ok); end
    tests++; if (err_count !== 8'd1) begin fails++; $display("FAIL pat_b_err_count got %0d want 1", err_count); end
    tests++; if (frame_count !== 8'd2) begin fails++; $display("FAIL pat_b_frame_count got %0d want 2", frame_count); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_out_valid cyc %0d got %b want 1", i, out_valid); end
      tests++; if (frame_ok !== 1'b0) begin fails++; $display("FAIL bp_frame_ok cyc %0d got %b want 0", i, frame_ok); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready cyc %0d got %b want 0", i, in_ready); end
    end
    step(1'b1, 1'b1, 1'b1, 1'b0);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL bp_handshake_busy got %b want 0", busy); end
    step(1'b1, 1'b1, 1'b1, 1'b0);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL bp_next_accept_busy got %b want 1", busy); end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_second_frame_valid got %b want 1", out_valid); end
    tests++; if (frame_count !== 8'd2) begin fails++; $display("FAIL bp_second_frame_count got %0d want 2", frame_count); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    model_clear();
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL arst_busy got %b want 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL arst_out_valid got %b want 1", out_valid); end
    tests++; if (frame_ok !== 1'b1) begin fails++; $display("FAIL arst_frame_ok got %b want 1", frame_ok); end
    tests++; if (frame_count !== 8'd1) begin fails++; $display("FAIL arst_frame_count got %0d want 1", frame_count); end
  endtask

  task automatic test_soft_clr();
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL sclr_out_valid got %b want 0", out_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL sclr_busy got %b want 0", busy); end
    tests++; if (frame_count !== 8'd0) begin fails++; $display("FAIL sclr_frame_count got %0d want 0", frame_count); end
    tests++; if (err_count !== 8'd0) begin fails++; $display("FAIL sclr_err_count got %0d want 0", err_count); end
  endtask

  task automatic test_random();
    bit iv, ix, ordy, sclr;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ix   = $urandom_range(0, 1);
      ordy = ($urandom_range(0, 2) != 0);
      sclr = ($urandom_range(0, 99) == 0);
      step(iv, ix, ordy, sclr);
      tests++; if (out_valid !== m_report) begin fails++; $display("FAIL rnd_out_valid cyc %0d got %b want %b", c, out_valid, m_report); end
      tests++; if (in_ready !== !m_report) begin fails++; $display("FAIL rnd_in_ready cyc %0d got %b want %b", c, in_ready, !m_report); end
      tests++; if (busy !== (m_report || q.size() > 0)) begin fails++; $display("FAIL rnd_busy cyc %0d got %b want %b", c, busy, (m_report || q.size() > 0)); end
      tests++; if (frame_count !== 8'(m_fc)) begin fails++; $display("FAIL rnd_frame_count cyc %0d got %0d want %0d", c, frame_count, m_fc); end
      tests++; if (err_count !== 8'(m_ec)) begin fails++; $display("FAIL rnd_err_count cyc %0d got %0d want %0d", c, err_count, m_ec); end
      if (m_report) begin
        tests++; if (frame_ok !== m_ok) begin fails++; $display("FAIL rnd_frame_ok cyc %0d got %b want %b", c, frame_ok, m_ok); end
      end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int f = 0; f < 300; f++) begin
      for (int b = 0; b < FRAME_LEN; b++) step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
    end
    tests++; if (err_count !== 8'd255) begin fails++; $display("FAIL sat_err_count got %0d want 255", err_count); end
    tests++; if (frame_count !== 8'd44) begin fails++; $display("FAIL sat_frame_count got %0d want 44", frame_count); end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    soft_clr  = 1'b0;
    in_valid  = 1'b0;
    in_xnor   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic_frame();
    test_patterns();
    test_backpressure();
    test_async_reset();
    test_soft_clr();
    test_random();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
